// File: rtl/dense_pkg.sv
// dense_pkg: types shared by the dense-layer weight sequencer.
//   dense_seq_state_t : sequencer FSM states (IDLE / ISSUE / DRAIN)
//   dense_w_tag_t     : per-word tag carried from issue to the FIFO head
//                       (neuron index, last word of neuron, last word of run)
// DENSE_MAX_OUT sizes the neuron field in the tag; the sequencer's MAX_OUT
// must not exceed it.
package dense_pkg;

  localparam int DENSE_MAX_OUT = 256;
  localparam int DENSE_OW      = $clog2(DENSE_MAX_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } dense_seq_state_t;

  typedef struct packed {
    logic [DENSE_OW-1:0] neuron;
    logic                row_last;
    logic                last;
  } dense_w_tag_t;

  localparam int DENSE_TAG_W = $bits(dense_w_tag_t);

endpackage

// File: rtl/dense_weight_sequencer_if.sv
// dense_weight_sequencer_if: weight stream from the sequencer to the MAC.
//   w_valid / w_ready : handshake, a word moves when both are high
//   w_data            : weight word
//   w_neuron          : output-neuron index of w_data
//   w_row_last        : last word of the current neuron
//   w_last            : last word of the run
// Modports: master (sequencer side), slave (consumer side).
interface dense_weight_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int OW    = 9
);

  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w_data;
  logic [OW-1:0]    w_neuron;
  logic             w_row_last;
  logic             w_last;

  modport master (
    output w_valid, w_data, w_neuron, w_row_last, w_last,
    input  w_ready
  );

  modport slave (
    input  w_valid, w_data, w_neuron, w_row_last, w_last,
    output w_ready
  );

endinterface

// File: rtl/weight_skid_fifo.sv
// weight_skid_fifo: 2-entry FIFO holding ROM words plus their tags.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write one entry (ignored when full without a same-cycle pop)
//   pop        : retire the head entry (ignored when empty)
//   dout       : head entry, stable until popped
//   occ        : number of stored entries (0..2)
//   empty/full : occupancy flags
module weight_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign occ   = cnt;
  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);

endmodule

// File: rtl/dense_weight_sequencer.sv
// dense_weight_sequencer: walks out_neurons x in_words consecutive weight-ROM
// words from base_addr, absorbs the ROM's one-cycle read latency and streams
// each word out with neuron / row-last / last tags.
//   clk, reset       : clock, asynchronous active-low reset
//   start            : launch a run (sampled only while idle)
//   base_addr, in_words, out_neurons : run configuration, latched at start
//   busy, done       : run in progress, one-cycle completion pulse
//   err              : bounds error (sticky until the next accepted start)
//   rom_addr, rom_read_enable, rom_weight_in : weight ROM port
//   w                : weight stream (master side)
// Optional feature: define DENSE_SEQ_BOUNDS_CHECK_EN to reject runs whose
// address range would run past the end of the ROM; otherwise addresses wrap
// modulo DEPTH and err is tied low.
module dense_weight_sequencer
  import dense_pkg::*;
#(
  parameter  int DEPTH        = 16384,
  parameter  int WIDTH        = 32,
  parameter  int MAX_IN_WORDS = 256,
  parameter  int MAX_OUT      = 256,
  localparam int AW           = $clog2(DEPTH),
  localparam int IW           = $clog2(MAX_IN_WORDS + 1),
  localparam int OW           = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [IW-1:0]       in_words,
  input  logic [OW-1:0]       out_neurons,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [AW-1:0]       rom_addr,
  output logic                rom_read_enable,
  input  logic [WIDTH-1:0]    rom_weight_in,
  dense_weight_sequencer_if.master w
);

  localparam int PW = WIDTH + DENSE_TAG_W;

  dense_seq_state_t state;
  logic [AW-1:0]    addr_cnt;
  logic [IW-1:0]    word_cnt;
  logic [IW-1:0]    cfg_in;
  logic [OW-1:0]    neuron_cnt;
  logic [OW-1:0]    cfg_out;
  logic             inflight_v;
  dense_w_tag_t     inflight_tag;
  dense_w_tag_t     issue_tag;
  dense_w_tag_t     head_tag;

  logic [1:0]       occ;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [PW-1:0]    fifo_din;
  logic [PW-1:0]    fifo_dout;

  logic [2:0]       credit;
  logic             issue;
  logic             row_end;
  logic             run_end;

`ifdef DENSE_SEQ_BOUNDS_CHECK_EN
  localparam int SW = AW + IW + OW + 1;
  logic [SW-1:0] span;
  logic          oob;
  logic          err_q;

  assign span = SW'(base_addr) + SW'(in_words) * SW'(out_neurons);
  assign oob  = span > SW'(DEPTH);
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

  assign pop = !fifo_empty && w.w_ready;

  // Entries that will hold a FIFO slot once this cycle settles: stored words
  // plus the read whose data arrives now, minus a word leaving now. A read
  // issued this cycle lands one cycle later, so below 2 it always has a slot.
  // The read strobe reacts to this in the same cycle, hence combinational.
  assign credit = {1'b0, occ} + {2'b00, inflight_v} - {2'b00, pop};
  assign issue  = (state == S_ISSUE) && (credit < 3'd2);

  assign row_end = (word_cnt == cfg_in - IW'(1));
  assign run_end = row_end && (neuron_cnt == cfg_out - OW'(1));

  always_comb begin
    issue_tag          = '0;
    issue_tag.neuron   = DENSE_OW'(neuron_cnt);
    issue_tag.row_last = row_end;
    issue_tag.last     = run_end;
  end

  assign rom_addr        = addr_cnt;
  assign rom_read_enable = issue;

  assign push     = inflight_v && (!fifo_full || pop);
  assign fifo_din = {rom_weight_in, inflight_tag};

  weight_skid_fifo #(
    .W (PW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .occ   (occ),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign head_tag     = fifo_dout[DENSE_TAG_W-1:0];
  assign w.w_valid    = !fifo_empty;
  assign w.w_data     = fifo_dout[PW-1 -: WIDTH];
  assign w.w_neuron   = OW'(head_tag.neuron);
  assign w.w_row_last = head_tag.row_last;
  assign w.w_last     = head_tag.last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      addr_cnt     <= '0;
      word_cnt     <= '0;
      neuron_cnt   <= '0;
      cfg_in       <= '0;
      cfg_out      <= '0;
      inflight_v   <= 1'b0;
      inflight_tag <= '0;
`ifdef DENSE_SEQ_BOUNDS_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      done         <= 1'b0;
      inflight_v   <= issue;
      inflight_tag <= issue_tag;
      unique case (state)
        S_IDLE: begin
          if (start) begin
`ifdef DENSE_SEQ_BOUNDS_CHECK_EN
            err_q <= 1'b0;
`endif
            if ((in_words == '0) || (out_neurons == '0)) begin
              done <= 1'b1;
            end
`ifdef DENSE_SEQ_BOUNDS_CHECK_EN
            else if (oob) begin
              err_q <= 1'b1;
              done  <= 1'b1;
            end
`endif
            else begin
              cfg_in     <= in_words;
              cfg_out    <= out_neurons;
              addr_cnt   <= base_addr;
              word_cnt   <= '0;
              neuron_cnt <= '0;
              busy       <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_cnt <= addr_cnt + AW'(1);
            if (row_end) begin
              word_cnt   <= '0;
              neuron_cnt <= neuron_cnt + OW'(1);
            end else begin
              word_cnt <= word_cnt + IW'(1);
            end
            if (run_end) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The run ends on the handshake of the word tagged last; every
          // earlier word has already left the FIFO by then.
          if (pop && head_tag.last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_weight_sequencer.sv
module tb_dense_weight_sequencer;

  localparam int DEPTH = 16384;
  localparam int WIDTH = 32;
  localparam int AW    = 14;
  localparam int IW    = 9;
  localparam int OW    = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [IW-1:0]    in_words = '0;
  logic [OW-1:0]    out_neurons = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic [AW-1:0]    rom_addr;
  logic             rom_read_enable;
  logic [WIDTH-1:0] rom_weight_in;

  dense_weight_sequencer_if #(.WIDTH(WIDTH), .OW(OW)) w_if ();

  dense_weight_sequencer #(
    .DEPTH        (DEPTH),
    .WIDTH        (WIDTH),
    .MAX_IN_WORDS (256),
    .MAX_OUT      (256)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .in_words        (in_words),
    .out_neurons     (out_neurons),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .rom_addr        (rom_addr),
    .rom_read_enable (rom_read_enable),
    .rom_weight_in   (rom_weight_in),
    .w               (w_if)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle read latency; garbage when not read.
  logic [WIDTH-1:0] rom [DEPTH];
  always @(posedge clk) rom_weight_in <= rom_read_enable ? rom[rom_addr] : $urandom;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always high, 1 = pattern 1,0,0,1, 2 = random.
  int ready_mode = 0;
  int rpat = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: w_if.w_ready = 1'b1;
      1: begin
        w_if.w_ready = ((rpat % 4) == 0) || ((rpat % 4) == 3);
        rpat++;
      end
      default: w_if.w_ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct {
    logic [31:0] d;
    logic [8:0]  n;
    logic        rl;
    logic        l;
    int          c;
  } obs_t;

  obs_t obs_q[$];
  obs_t exp_q[$];
  int   rd_addr_q[$];
  int   rd_cyc_q[$];
  int   exp_addr_q[$];
  int   done_q[$];
  int   busy_cnt = 0;
  int   stab_viol = 0;
  logic stall_prev = 1'b0;
  logic [31:0] prev_data = '0;

  // Passive recorder; all judging happens in the test tasks.
  always @(negedge clk) begin
    if (rom_read_enable) begin
      rd_addr_q.push_back(int'(rom_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (w_if.w_valid && stall_prev && (w_if.w_data !== prev_data)) stab_viol++;
    if (w_if.w_valid && w_if.w_ready)
      obs_q.push_back('{w_if.w_data, w_if.w_neuron, w_if.w_row_last, w_if.w_last, cyc});
    if (done) done_q.push_back(cyc);
    if (busy) busy_cnt++;
    stall_prev = w_if.w_valid && !w_if.w_ready;
    prev_data  = w_if.w_data;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int t0 = 0;

  task automatic clear_rec();
    obs_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    done_q.delete();
    busy_cnt  = 0;
    stab_viol = 0;
  endtask

  // Reference: the run reads base..base+N-1 (mod DEPTH) in neuron-major order.
  task automatic build_exp(input int base, input int iw, input int on);
    exp_q.delete();
    exp_addr_q.delete();
    for (int n = 0; n < on; n++) begin
      for (int k = 0; k < iw; k++) begin
        int a;
        logic [8:0] nn;
        a  = (base + n * iw + k) % DEPTH;
        nn = 9'(n);
        exp_addr_q.push_back(a);
        exp_q.push_back('{rom[a], nn, (k == iw - 1), (k == iw - 1) && (n == on - 1), 0});
      end
    end
  endtask

  // Start is sampled at the edge that ends the cycle in which t0 is taken.
  task automatic launch(input int base, input int iw, input int on);
    @(posedge clk);
    #1;
    clear_rec();
    base_addr   = AW'(base);
    in_words    = IW'(iw);
    out_neurons = OW'(on);
    start       = 1'b1;
    t0          = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (rom_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_re got %b want 0", rom_read_enable); end
    n_cmp++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", rom_addr); end
    n_cmp++; if (w_if.w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", w_if.w_valid); end
    n_cmp++; if (w_if.w_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", w_if.w_data); end
    n_cmp++; if ({w_if.w_neuron, w_if.w_row_last, w_if.w_last} !== '0) begin
      n_fail++; $display("FAIL reset_tags got %h want 0", {w_if.w_neuron, w_if.w_row_last, w_if.w_last});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_basic(input string tag);
    bit ok;
    ready_mode = 0;
    build_exp(16, 3, 2);
    launch(16, 3, 2);
    wait_done(40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_done_timeout got none want pulse", tag); end
    n_cmp++; if (rd_addr_q.size() !== 6) begin n_fail++; $display("FAIL %s_reads got %0d want 6", tag, rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < 6; i++) begin
      n_cmp++;
      if (rd_addr_q[i] !== 16 + i || rd_cyc_q[i] - t0 !== 1 + i) begin
        n_fail++; $display("FAIL %s_read%0d got addr %0d cyc %0d want addr %0d cyc %0d",
                           tag, i, rd_addr_q[i], rd_cyc_q[i] - t0, 16 + i, 1 + i);
      end
    end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL %s_words got %0d want %0d", tag, obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].n !== exp_q[i].n || obs_q[i].rl !== exp_q[i].rl ||
          obs_q[i].l !== exp_q[i].l || obs_q[i].c - t0 !== 3 + i) begin
        n_fail++; $display("FAIL %s_word%0d got d=%h n=%0d rl=%b l=%b cyc=%0d want d=%h n=%0d rl=%b l=%b cyc=%0d",
                           tag, i, obs_q[i].d, obs_q[i].n, obs_q[i].rl, obs_q[i].l, obs_q[i].c - t0,
                           exp_q[i].d, exp_q[i].n, exp_q[i].rl, exp_q[i].l, 3 + i);
      end
    end
    n_cmp++; if (done_q.size() !== 1) begin n_fail++; $display("FAIL %s_done_count got %0d want 1", tag, done_q.size()); end
    n_cmp++; if (done_q.size() > 0 && done_q[0] - t0 !== 9) begin n_fail++; $display("FAIL %s_done_cycle got %0d want 9", tag, done_q[0] - t0); end
    n_cmp++; if (busy_cnt !== 8) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 8", tag, busy_cnt); end
  endtask

  task automatic test_stall();
    bit ok;
    int last_c;
    ready_mode = 1;
    rpat = 0;
    build_exp(16, 3, 2);
    launch(16, 3, 2);
    wait_done(80, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_done_timeout got none want pulse"); end
    n_cmp++; if (obs_q.size() !== 6) begin n_fail++; $display("FAIL stall_words got %0d want 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].n !== exp_q[i].n || obs_q[i].rl !== exp_q[i].rl || obs_q[i].l !== exp_q[i].l) begin
        n_fail++; $display("FAIL stall_word%0d got d=%h n=%0d rl=%b l=%b want d=%h n=%0d rl=%b l=%b",
                           i, obs_q[i].d, obs_q[i].n, obs_q[i].rl, obs_q[i].l, exp_q[i].d, exp_q[i].n, exp_q[i].rl, exp_q[i].l);
      end
    end
    n_cmp++; if (stab_viol !== 0) begin n_fail++; $display("FAIL stall_data_stable got %0d changes want 0", stab_viol); end
    last_c = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].c : -100;
    n_cmp++; if (done_q.size() !== 1 || done_q[0] !== last_c + 1) begin
      n_fail++; $display("FAIL stall_done got count %0d want 1 after last handshake", done_q.size());
    end
    ready_mode = 0;
  endtask

  task automatic test_zero();
    bit ok;
    for (int z = 0; z < 2; z++) begin
      launch(5, (z == 0) ? 0 : 4, (z == 0) ? 3 : 0);
      wait_done(10, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL zero%0d_done_timeout got none want pulse", z); end
      n_cmp++; if (done_q.size() !== 1 || done_q[0] - t0 !== 1) begin
        n_fail++; $display("FAIL zero%0d_done got count %0d want one pulse at cycle 1", z, done_q.size());
      end
      n_cmp++; if (rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL zero%0d_reads got %0d want 0", z, rd_addr_q.size()); end
      n_cmp++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL zero%0d_busy got %0d cycles want 0", z, busy_cnt); end
    end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    ready_mode = 0;
    build_exp(16, 3, 2);
    launch(16, 3, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    base_addr = AW'(100); in_words = IW'(5); out_neurons = OW'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL restart_done_timeout got none want pulse"); end
    n_cmp++; if (obs_q.size() !== 6 || rd_addr_q.size() !== 6) begin
      n_fail++; $display("FAIL restart_count got words %0d reads %0d want 6 and 6", obs_q.size(), rd_addr_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].l !== exp_q[i].l) begin
        n_fail++; $display("FAIL restart_word%0d got d=%h l=%b want d=%h l=%b", i, obs_q[i].d, obs_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
    n_cmp++; if (done_q.size() !== 1) begin n_fail++; $display("FAIL restart_done_count got %0d want 1", done_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    launch(16, 3, 2);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    n_cmp++; if ({busy, done, err, rom_read_enable, w_if.w_valid} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_ctrl got %b want 00000", {busy, done, err, rom_read_enable, w_if.w_valid});
    end
    n_cmp++; if (rom_addr !== '0 || w_if.w_data !== '0) begin
      n_fail++; $display("FAIL midreset_bus got addr %h data %h want 0 0", rom_addr, w_if.w_data);
    end
    n_cmp++; if ({w_if.w_neuron, w_if.w_row_last, w_if.w_last} !== '0) begin
      n_fail++; $display("FAIL midreset_tags got %h want 0", {w_if.w_neuron, w_if.w_row_last, w_if.w_last});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    test_basic("after_reset");
  endtask

  task automatic test_bounds();
    bit ok;
    ready_mode = 0;
`ifdef DENSE_SEQ_BOUNDS_CHECK_EN
    launch(16380, 4, 2);
    wait_done(10, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bounds_done_timeout got none want pulse"); end
    n_cmp++; if (done_q.size() !== 1 || done_q[0] - t0 !== 1) begin
      n_fail++; $display("FAIL bounds_done got count %0d want one pulse at cycle 1", done_q.size());
    end
    n_cmp++; if (rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL bounds_reads got %0d want 0", rd_addr_q.size()); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bounds_err_sticky got %b want 1", err); end
    launch(16376, 4, 2);
    wait_done(40, ok);
    n_cmp++; if (err !== 1'b0 || rd_addr_q.size() !== 8) begin
      n_fail++; $display("FAIL bounds_fit got err %b reads %0d want err 0 reads 8", err, rd_addr_q.size());
    end
`else
    build_exp(16380, 4, 2);
    launch(16380, 4, 2);
    wait_done(40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout got none want pulse"); end
    n_cmp++; if (rd_addr_q.size() !== 8) begin n_fail++; $display("FAIL wrap_reads got %0d want 8", rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < exp_addr_q.size(); i++) begin
      n_cmp++; if (rd_addr_q[i] !== exp_addr_q[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d got %0d want %0d", i, rd_addr_q[i], exp_addr_q[i]);
      end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i].d !== exp_q[i].d) begin
        n_fail++; $display("FAIL wrap_word%0d got %h want %h", i, obs_q[i].d, exp_q[i].d);
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b want 0", err); end
`endif
  endtask

  task automatic test_random();
    bit ok;
    int iw, on, base, last_c;
    ready_mode = 2;
    for (int it = 0; it < 8; it++) begin
      iw = $urandom_range(1, 5);
      on = $urandom_range(1, 4);
`ifdef DENSE_SEQ_BOUNDS_CHECK_EN
      base = $urandom_range(0, DEPTH - iw * on);
`else
      base = $urandom_range(0, DEPTH - 1);
`endif
      build_exp(base, iw, on);
      launch(base, iw, on);
      wait_done(40 * iw * on + 40, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand%0d_done_timeout got none want pulse", it); end
      n_cmp++; if (obs_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_words got %0d want %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].n !== exp_q[i].n || obs_q[i].rl !== exp_q[i].rl || obs_q[i].l !== exp_q[i].l) begin
          n_fail++; $display("FAIL rand%0d_word%0d got d=%h n=%0d rl=%b l=%b want d=%h n=%0d rl=%b l=%b",
                             it, i, obs_q[i].d, obs_q[i].n, obs_q[i].rl, obs_q[i].l, exp_q[i].d, exp_q[i].n, exp_q[i].rl, exp_q[i].l);
        end
      end
      n_cmp++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rand%0d_data_stable got %0d changes want 0", it, stab_viol); end
      last_c = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].c : -100;
      n_cmp++; if (done_q.size() !== 1 || done_q[0] !== last_c + 1) begin
        n_fail++; $display("FAIL rand%0d_done got count %0d want one pulse after last handshake", it, done_q.size());
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    test_reset();
    test_basic("basic");
    test_stall();
    test_zero();
    test_restart_ignored();
    test_reset_mid_run();
    test_bounds();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_weight_sequencer.md
# dense_weight_sequencer

Sequences reads of the dense-layer weight ROM for one fully-connected layer: walks `out_neurons × in_words` consecutive ROM words from `base_addr` and drives the ROM's `addr` and `read_enable`. It absorbs the ROM's 1-cycle read latency and presents each word downstream on a valid/ready stream tagged with row/last markers. It sits between the layer controller (start/done) and the dense MAC datapath (stream consumer).

## Interface
- `DEPTH`, 16384, ROM depth in words; power of two; `AW = $clog2(DEPTH)`.
- `WIDTH`, 32, ROM word width.
- `MAX_IN_WORDS`, 256, max words per output neuron; `IW = $clog2(MAX_IN_WORDS+1)`.
- `MAX_OUT`, 256, max output neurons; `OW = $clog2(MAX_OUT+1)`.
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: launch a run; sampled only in IDLE.
- `base_addr` input AW: first ROM word address, latched at `start`.
- `in_words` input IW: words per neuron, latched at `start`.
- `out_neurons` input OW: neuron count, latched at `start`.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: bounds error; present only with the macro, otherwise tied 0.
- `rom_addr` output AW: address driven to the ROM.
- `rom_read_enable` output 1: ROM read strobe.
- `rom_weight_in` input WIDTH: ROM data, valid the cycle after a read.
- `w_valid` output 1, `w_ready` input 1: downstream handshake.
- `w_data` output WIDTH: weight word.
- `w_neuron` output OW-1..0: neuron index of `w_data`.
- `w_row_last` output 1: last word of the current neuron.
- `w_last` output 1: last word of the run.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - `start` with `in_words`≠0 and `out_neurons`≠0: latch the config, go to ISSUE.
  - `start` with either count 0: no reads; `done` pulses the next cycle.
- ISSUE: issue one read per cycle while `credit = occ + inflight − pop < 2`.
  - `occ` is the FIFO occupancy, `inflight` is a read issued last cycle, and `pop` is `w_valid && w_ready`.
  - Address counter starts at `base_addr` and increments by 1, mod DEPTH.
  - Word counter wraps at `in_words`, then increments the neuron counter.
  - After the final read is issued, go to DRAIN.
- Tags: `w_neuron`, `w_row_last` and `w_last` are computed at issue and carried with the read through the pipeline into the FIFO.
- DRAIN: wait until FIFO empty and nothing in flight; then `done` pulses and go to IDLE.
- `start` is ignored while `busy`.
- FIFO is 2 entries. The `w_*` outputs are the head entry. `w_data` is held stable while `w_valid && !w_ready`.
- FIFO push and pop in the same cycle leave occupancy unchanged. Overflow is impossible by credit construction.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rom_read_enable`=0, `rom_addr`=0, `w_valid`=0, `w_data`=0, all tags 0, FIFO empty, state IDLE.
- `start` sampled in cycle 0:
  - `busy` high from cycle 1.
  - First `rom_read_enable` in cycle 1.
  - ROM data arrives in cycle 2 and is pushed at the end of cycle 2.
  - First `w_valid` in cycle 3.
- With `w_ready` held high: one word per cycle, no bubbles. Last word at cycle `2 + N`, where `N = in_words·out_neurons`.
- `done` is registered and high for one cycle, the cycle after the handshake of the `w_last` word. `busy` falls in that same cycle.
- `w_ready` low: issue stalls within one cycle. Nothing is lost; the ROM read result always has a FIFO slot.
- Reset asserted mid-run: immediate return to IDLE. In-flight data and FIFO contents are discarded.

## Configuration
- Macro: `DENSE_SEQ_BOUNDS_CHECK_EN`.
- Defined:
  - At `start`, if `base_addr + N > DEPTH`: no reads are issued.
  - `err` is set and `done` pulses the next cycle.
  - `err` is sticky until the next accepted `start`.
- Undefined: no check is made; addresses wrap mod DEPTH; `err` is tied 0.

## Structure
- Shared package `dense_pkg`: state enum `dense_seq_state_t` and a tag struct `dense_w_tag_t` holding neuron, row_last and last.
- One sub-module, `weight_skid_fifo`: a 2-entry FIFO parameterized on a payload width of WIDTH plus the tag width. Ports: push, pop, data in/out, occ, empty, full.

## Test plan
- `base_addr`=0x10, `in_words`=3, `out_neurons`=2, `w_ready`=1 → addresses 0x10–0x15 in cycles 1–6. `w_valid` in cycles 3–8 carries ROM[0x10..0x15]. `w_row_last` on words 3 and 6, `w_last` on word 6. `done` in cycle 9.
- Same run with `w_ready` toggling 1,0,0,1 repeatedly → all 6 words delivered in order. No duplicated or dropped words. `w_data` stable during stalls.
- `in_words`=0 with `start` → no `rom_read_enable`. `done` the next cycle. `busy` never asserts.
- `start` pulsed again mid-run → ignored. Word count stays at 6.
- Reset low during cycle 4 of a run → all outputs take their reset values. A fresh `start` afterwards behaves as the first scenario.
- Macro defined, `base_addr`=16380, `in_words`=4, `out_neurons`=2 → `err`=1, no reads, `done` the next cycle.
- Macro undefined, same config → addresses 16380–16383, then 0–3.
